// File: rtl/boron_pkg.sv
// boron_pkg: shared constants and types for the BORON decryption key schedule.
// The key register holds KEY_W bits, and each round key is its low RK_W bits.
package boron_pkg;

    localparam int ROUNDS = 25;
    localparam int KEY_W  = 80;
    localparam int RK_W   = 64;
    localparam int ROT    = 13;
    localparam int RC_W   = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_ISSUE
    } state_e;

    typedef enum logic {
        DIR_FWD = 1'b0,
        DIR_REV = 1'b1
    } dir_e;

endpackage

// File: rtl/dec_key_schedule_if.sv
// dec_key_schedule_if: bundles the master-key and round-key handshake signals.
// The slave modport is for the key schedule. The master modport is for whoever
// drives it. Signal names are written from the key schedule's point of view.
interface dec_key_schedule_if;

    logic                         i_key_valid;
    logic                         o_key_ready;
    logic [boron_pkg::KEY_W-1:0]  i_key;
    logic                         o_rk_valid;
    logic                         i_rk_ready;
    logic [boron_pkg::RK_W-1:0]   o_rk;
    logic [boron_pkg::RC_W-1:0]   o_rk_idx;
    logic                         o_rk_last;
    logic                         o_busy;

    modport slave (
        input  i_key_valid, i_key, i_rk_ready,
        output o_key_ready, o_rk_valid, o_rk, o_rk_idx, o_rk_last, o_busy
    );

    modport master (
        output i_key_valid, i_key, i_rk_ready,
        input  o_key_ready, o_rk_valid, o_rk, o_rk_idx, o_rk_last, o_busy
    );

endinterface

// File: rtl/dec_s_box.sv
// dec_s_box: inverse of the BORON 4-bit substitution.
module dec_s_box (
    input  logic [3:0] x_i,
    output logic [3:0] y_o
);

    // Table lookup of the inverse S-box.
    always_comb begin
        case (x_i)
            4'h0:    y_o = 4'hA;
            4'h1:    y_o = 4'h3;
            4'h2:    y_o = 4'h9;
            4'h3:    y_o = 4'hE;
            4'h4:    y_o = 4'h1;
            4'h5:    y_o = 4'hD;
            4'h6:    y_o = 4'hF;
            4'h7:    y_o = 4'h4;
            4'h8:    y_o = 4'hC;
            4'h9:    y_o = 4'h5;
            4'hA:    y_o = 4'h7;
            4'hB:    y_o = 4'h2;
            4'hC:    y_o = 4'h6;
            4'hD:    y_o = 4'h8;
            4'hE:    y_o = 4'h0;
            default: y_o = 4'hB;
        endcase
    end

endmodule

// File: rtl/ks_step.sv
// ks_step: one combinational BORON key-schedule step in either direction.
// Forward takes K_{rc-1} to K_rc. Reverse takes K_rc back to K_{rc-1}.
module ks_step
    import boron_pkg::*;
(
    input  logic [KEY_W-1:0] k_i,
    input  logic [RC_W-1:0]  rc_i,
    input  dir_e             dir_i,
    output logic [KEY_W-1:0] k_o
);

    logic [KEY_W-1:0] rotL;
    logic [KEY_W-1:0] fwdK;
    logic [KEY_W-1:0] revPre;
    logic [KEY_W-1:0] revK;
    logic [3:0]       sOut;
    logic [3:0]       sInvOut;

    assign rotL = (k_i << ROT) | (k_i >> (KEY_W - ROT));

    s_box uSBox (
        .x_i (rotL[3:0]),
        .y_o (sOut)
    );

    // The round-constant XOR on [63:59] does not touch nibble [3:0], so the
    // inverse S-box can look at the incoming key directly.
    dec_s_box uDecSBox (
        .x_i (k_i[3:0]),
        .y_o (sInvOut)
    );

    assign fwdK = {rotL[KEY_W-1:RK_W],
                   rotL[RK_W-1 -: RC_W] ^ rc_i,
                   rotL[RK_W-RC_W-1:4],
                   sOut};

    assign revPre = {k_i[KEY_W-1:RK_W],
                     k_i[RK_W-1 -: RC_W] ^ rc_i,
                     k_i[RK_W-RC_W-1:4],
                     sInvOut};

    assign revK = (revPre >> ROT) | (revPre << (KEY_W - ROT));

    assign k_o = (dir_i == DIR_REV) ? revK : fwdK;

endmodule

// File: rtl/s_box.sv
// s_box: BORON forward 4-bit substitution.
module s_box (
    input  logic [3:0] x_i,
    output logic [3:0] y_o
);

    // Table lookup of the forward S-box.
    always_comb begin
        case (x_i)
            4'h0:    y_o = 4'hE;
            4'h1:    y_o = 4'h4;
            4'h2:    y_o = 4'hB;
            4'h3:    y_o = 4'h1;
            4'h4:    y_o = 4'h7;
            4'h5:    y_o = 4'h9;
            4'h6:    y_o = 4'hC;
            4'h7:    y_o = 4'hA;
            4'h8:    y_o = 4'hD;
            4'h9:    y_o = 4'h2;
            4'hA:    y_o = 4'h0;
            4'hB:    y_o = 4'hF;
            4'hC:    y_o = 4'h8;
            4'hD:    y_o = 4'h5;
            4'hE:    y_o = 4'h3;
            default: y_o = 4'h6;
        endcase
    end

endmodule

// File: rtl/dec_key_schedule.sv
// dec_key_schedule: iterative BORON decryption key schedule.
// The block expands an 80-bit master key forward to K_ROUNDS. It then issues
// K_ROUNDS..K_0 over a valid/ready handshake by undoing one step per beat.
// Optional macro DEC_KS_CACHE_EN keeps the last master key and its K_ROUNDS,
// so a repeated key goes straight to issuing without expansion.
module dec_key_schedule
    import boron_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    dec_key_schedule_if.slave bus
);

    state_e           state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [RC_W-1:0]  rc_q, rc_d;
    logic [RC_W-1:0]  idx_q, idx_d;

    logic [KEY_W-1:0] stepK;
    logic [RC_W-1:0]  stepRc;
    dir_e             stepDir;

    logic             keyAccept;
    logic             rkFire;
    logic             expandDone;
    logic             cacheHit;
    logic [KEY_W-1:0] cacheRk;

    logic             keyReady;
    logic             rkValid;
    logic             rkLast;
    logic             busy;
    logic [RK_W-1:0]  rk;

    assign keyAccept  = (state_q == ST_IDLE) && bus.i_key_valid;
    assign rkFire     = (state_q == ST_ISSUE) && bus.i_rk_ready;
    assign expandDone = (state_q == ST_EXPAND) && (rc_q == RC_W'(ROUNDS));

`ifdef DEC_KS_CACHE_EN
    logic [KEY_W-1:0] cacheKey_q;
    logic [KEY_W-1:0] cacheRk_q;
    logic             cacheValid_q;

    assign cacheHit = cacheValid_q && (bus.i_key == cacheKey_q);
    assign cacheRk  = cacheRk_q;

    // Forget the cache when a new key arrives, then capture its K_ROUNDS once expansion completes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cacheValid_q <= 1'b0;
            cacheKey_q   <= '0;
            cacheRk_q    <= '0;
        end else if (keyAccept && !cacheHit) begin
            cacheValid_q <= 1'b0;
            cacheKey_q   <= bus.i_key;
        end else if (expandDone) begin
            cacheValid_q <= 1'b1;
            cacheRk_q    <= stepK;
        end
    end
`else
    assign cacheHit = 1'b0;
    assign cacheRk  = '0;
`endif

    // The same step unit runs forward during expansion and backward while issuing.
    assign stepDir = (state_q == ST_ISSUE) ? DIR_REV : DIR_FWD;
    assign stepRc  = (state_q == ST_ISSUE) ? idx_q : rc_q;

    ks_step uStep (
        .k_i   (key_q),
        .rc_i  (stepRc),
        .dir_i (stepDir),
        .k_o   (stepK)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: IDLE -> EXPAND (or ISSUE on a cache hit) -> ISSUE -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (keyAccept) begin
                    state_d = cacheHit ? ST_ISSUE : ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                if (expandDone) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (rkFire && (idx_q == '0)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Moore outputs. The round key is only driven while a beat is being offered.
    always_comb begin
        keyReady = 1'b0;
        rkValid  = 1'b0;
        rkLast   = 1'b0;
        busy     = 1'b1;
        rk       = '0;
        case (state_q)
            ST_IDLE: begin
                keyReady = 1'b1;
                busy     = 1'b0;
            end
            ST_ISSUE: begin
                rkValid = 1'b1;
                rk      = key_q[RK_W-1:0];
                rkLast  = (idx_q == '0);
            end
            default: ;
        endcase
    end

    assign bus.o_key_ready = keyReady;
    assign bus.o_rk_valid  = rkValid;
    assign bus.o_rk        = rk;
    assign bus.o_rk_idx    = idx_q;
    assign bus.o_rk_last   = rkLast;
    assign bus.o_busy      = busy;

    // Datapath next values: load the key, step forward during expansion, and step back on each accepted beat.
    always_comb begin
        key_d = key_q;
        rc_d  = rc_q;
        idx_d = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (keyAccept) begin
                    if (cacheHit) begin
                        key_d = cacheRk;
                        idx_d = RC_W'(ROUNDS);
                    end else begin
                        key_d = bus.i_key;
                        rc_d  = RC_W'(1);
                    end
                end
            end
            ST_EXPAND: begin
                key_d = stepK;
                rc_d  = rc_q + RC_W'(1);
                if (expandDone) begin
                    idx_d = RC_W'(ROUNDS);
                end
            end
            ST_ISSUE: begin
                if (rkFire && (idx_q != '0)) begin
                    key_d = stepK;
                    idx_d = idx_q - RC_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers: the key register and the round and index counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            key_q <= '0;
            rc_q  <= '0;
            idx_q <= '0;
        end else begin
            key_q <= key_d;
            rc_q  <= rc_d;
            idx_q <= idx_d;
        end
    end

endmodule
